// File: rtl/vga_pkg.sv
// Shared video timing constants and the pixel-fetch FSM state type.
package vga_pkg;
   localparam int H_ACTIVE  = 800;
   localparam int H_TOTAL   = 1040;
   localparam int V_ACTIVE  = 600;
   localparam int V_TOTAL   = 666;
   localparam int FB_PIXELS = 480000;

   typedef enum logic [1:0] {
      S_SYNC,
      S_FETCH,
      S_DONE
   } fetch_state_t;
endpackage

// File: rtl/fb_fifo.sv
// Single-clock pixel FIFO with occupancy output and a synchronous flush.
module fb_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 24,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_empty
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rdPtr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wrPtr] <= i_data;
   end
endmodule

// File: rtl/fb_pixel_fetch.sv
// Framebuffer reader: prefetches RGB words into a FIFO and pops one per active pixel.
// Define FB_TEST_PATTERN_EN to replace memory data with eight vertical colour bars.
module fb_pixel_fetch
   import vga_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_en,
   input  logic [10:0]       count,
   input  logic [9:0]        line,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [23:0]       mem_data,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              underflow
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS);

   fetch_state_t      r_state, w_nextState;
   logic [ADDR_W-1:0] r_addrCnt;
   logic              r_memReq;
   logic [ADDR_W-1:0] r_memAddr;
   logic              r_discard;
   logic [23:0]       r_rgb;
   logic              r_underflow;
   logic              w_active, w_frameStart, w_ackValid, w_push, w_pop;
   logic              w_fetching, w_issue;
   logic [23:0]       w_fifoData;
   logic [CW-1:0]     w_fifoCount;
   logic              w_fifoEmpty;

   assign w_active     = pix_en && (count < 11'(H_ACTIVE)) && (line < 10'(V_ACTIVE));
   assign w_frameStart = pix_en && (count == 11'd0) && (line == 10'(V_ACTIVE));
   assign w_ackValid   = mem_ack && r_memReq;
   assign w_push       = w_ackValid && !r_discard && !w_frameStart;
   assign w_pop        = w_active && !w_fifoEmpty;

   fb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_frameStart),
      .i_push  (w_push),
      .i_data  (mem_data),
      .i_pop   (w_pop),
      .o_data  (w_fifoData),
      .o_count (w_fifoCount),
      .o_empty (w_fifoEmpty)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_SYNC;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_SYNC:  if (w_frameStart) w_nextState = S_FETCH;
         S_FETCH: if (!w_frameStart && r_addrCnt == LAST_ADDR) w_nextState = S_DONE;
         S_DONE:  if (w_frameStart) w_nextState = S_FETCH;
         default: w_nextState = S_SYNC;
      endcase
   end

   // Counter reaching the frame size blocks issue in the same clk the FSM leaves S_FETCH.
   always_comb begin
      w_fetching = (r_state == S_FETCH) && (r_addrCnt != LAST_ADDR);
`ifdef FB_TEST_PATTERN_EN
      w_issue    = 1'b0;
`else
      w_issue    = w_fetching && !r_memReq && !w_frameStart &&
                   (w_fifoCount < CW'(FIFO_DEPTH));
`endif
   end

   // A request straddling frame-start still completes, but its word belongs to the old frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_memReq  <= 1'b0;
         r_memAddr <= '0;
         r_discard <= 1'b0;
      end else begin
         if (w_ackValid) begin
            r_memReq  <= 1'b0;
            r_discard <= 1'b0;
         end else if (w_issue) begin
            r_memReq  <= 1'b1;
            r_memAddr <= r_addrCnt;
         end
         if (w_frameStart && r_memReq && !mem_ack) r_discard <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_frameStart) r_addrCnt <= '0;
      else if (w_push)         r_addrCnt <= r_addrCnt + ADDR_W'(1);
   end

`ifdef FB_TEST_PATTERN_EN
   logic [2:0]  w_bar;
   logic [23:0] w_barColour;
   assign w_bar       = 3'(count / 11'd100);
   assign w_barColour = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb       <= '0;
         r_underflow <= 1'b0;
      end else if (pix_en) begin
`ifdef FB_TEST_PATTERN_EN
         r_rgb <= w_active ? w_barColour : 24'd0;
`else
         if (w_pop) begin
            r_rgb <= w_fifoData;
         end else begin
            r_rgb <= '0;
            if (w_active) r_underflow <= 1'b1;
         end
`endif
      end
   end

   assign mem_req   = r_memReq;
   assign mem_addr  = r_memAddr;
   assign red       = r_rgb[23:16];
   assign green     = r_rgb[15:8];
   assign blue      = r_rgb[7:0];
   assign underflow = r_underflow;
endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Self-checking bench for fb_pixel_fetch: table vectors, scoreboarded pixel stream and
// hand-written sequences for stalls, frame-start with a request in flight, and reset.
module tb_fb_pixel_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic [10:0] count;
   logic [9:0]  line;
   logic        mem_req;
   logic [18:0] mem_addr;
   logic        mem_ack;
   logic [23:0] mem_data;
   logic [7:0]  red, green, blue;
   logic        underflow;

   int          nVec = 0;
   int          nErr = 0;
   logic        stall = 1'b0;
   logic        spurious = 1'b0;
   logic [23:0] dataMask = 24'h5A0000;
   int          reqAge = 0;

   typedef struct {
      logic [23:0] rgb;
      logic        uf;
   } exp_t;

   typedef struct {
      logic [10:0] cnt;
      logic [9:0]  ln;
      logic [23:0] rgb;
      logic        uf;
   } vec_t;

   exp_t expQ[$];
   vec_t tbl[10];

   fb_pixel_fetch #(.FIFO_DEPTH(16), .ADDR_W(19)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_en    (pix_en),
      .count     (count),
      .line      (line),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] memWord(input logic [18:0] a);
      return 24'(a) ^ dataMask;
   endfunction

   // Memory model: ack in the second clk of a request unless stalled; optional stray ack.
   initial begin
      mem_ack  = 1'b0;
      mem_data = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            reqAge  = 0;
         end else if (spurious) begin
            mem_ack  = 1'b1;
            mem_data = 24'hFFFFFF;
            spurious = 1'b0;
         end else if (mem_req) begin
            reqAge++;
            if (!stall && reqAge > 1) begin
               mem_ack  = 1'b1;
               mem_data = memWord(mem_addr);
            end
         end else begin
            reqAge = 0;
         end
      end
   end

   task automatic checkVal(input string name, input logic [23:0] act, input logic [23:0] req);
      nVec++;
      if (act !== req) begin
         nErr++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      if (expQ.size() == 0) begin
         nVec++;
         nErr++;
         $display("[TB] FAIL %s: got no scoreboard entry, expected one", name);
      end else begin
         e = expQ.pop_front();
         checkVal({name, ".rgb"}, {red, green, blue}, e.rgb);
         checkVal({name, ".uf"}, 24'(underflow), 24'(e.uf));
      end
   endtask

   task automatic applyStimulus(input string name, input logic [10:0] c, input logic [9:0] l,
                                input logic [23:0] rgb, input logic uf);
      exp_t e;
      count  = c;
      line   = l;
      pix_en = 1'b1;
      e.rgb  = rgb;
      e.uf   = uf;
      expQ.push_back(e);
      @(negedge clk);
      pix_en = 1'b0;
      checkOutput(name);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitReq(input logic lvl, input int budget, input string name);
      int i = 0;
      while (mem_req !== lvl && i < budget) begin
         @(negedge clk);
         i++;
      end
      nVec++;
      if (mem_req !== lvl) begin
         nErr++;
         $display("[TB] FAIL %s: mem_req=%b after %0d clks, expected %b", name, mem_req, budget, lvl);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0] = '{11'd0,    10'd0,   24'h5A0000, 1'b0};
      tbl[1] = '{11'd1,    10'd0,   24'h5A0001, 1'b0};
      tbl[2] = '{11'd799,  10'd0,   24'h5A0002, 1'b0};
      tbl[3] = '{11'd800,  10'd0,   24'h000000, 1'b0};
      tbl[4] = '{11'd0,    10'd599, 24'h5A0003, 1'b0};
      tbl[5] = '{11'd5,    10'd600, 24'h000000, 1'b0};
      tbl[6] = '{11'd1039, 10'd665, 24'h000000, 1'b0};
      tbl[7] = '{11'd100,  10'd300, 24'h5A0004, 1'b0};
      tbl[8] = '{11'd1000, 10'd10,  24'h000000, 1'b0};
      tbl[9] = '{11'd2,    10'd1,   24'h5A0005, 1'b0};

      rst    = 1'b1;
      pix_en = 1'b0;
      count  = '0;
      line   = '0;
      idle(3);
      rst = 1'b0;
      checkVal("resetRgb", {red, green, blue}, 24'h0);
      checkVal("resetUf", 24'(underflow), 24'h0);
      checkVal("resetReq", 24'(mem_req), 24'h0);
      checkVal("resetAddr", 24'(mem_addr), 24'h0);

      idle(30);
      checkVal("syncNoReq", 24'(mem_req), 24'h0);

`ifdef FB_TEST_PATTERN_EN
      applyStimulus("patFs", 11'd0, 10'd600, 24'h000000, 1'b0);
      idle(40);
      applyStimulus("patBar0", 11'd0,   10'd0, 24'h000000, 1'b0);
      applyStimulus("patBar2", 11'd250, 10'd0, 24'h00FF00, 1'b0);
      applyStimulus("patBar4", 11'd450, 10'd3, 24'hFF0000, 1'b0);
      applyStimulus("patBar7", 11'd799, 10'd5, 24'hFFFFFF, 1'b0);
      applyStimulus("patBlank", 11'd900, 10'd0, 24'h000000, 1'b0);
      checkVal("patNoReq", 24'(mem_req), 24'h0);
`else
      applyStimulus("frameStart1", 11'd0, 10'd600, 24'h0, 1'b0);
      idle(80);
      for (int i = 0; i < 10; i++)
         applyStimulus($sformatf("table%0d", i), tbl[i].cnt, tbl[i].ln, tbl[i].rgb, tbl[i].uf);

      applyStimulus("frameStart2", 11'd0, 10'd600, 24'h0, 1'b0);
      idle(80);
      applyStimulus("frame2First", 11'd0, 10'd0, memWord(19'd0), 1'b0);

      dataMask = 24'h000000;
      applyStimulus("frameStart3", 11'd0, 10'd600, 24'h0, 1'b0);
      idle(80);
      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < 800; c++) begin
            if (l == 2 && c > 5) break;
            applyStimulus($sformatf("pix%0d_%0d", c, l), 11'(c), 10'(l), 24'(l * 800 + c), 1'b0);
            applyStimulus("blank", 11'd1000, 10'(l), 24'h0, 1'b0);
         end
      end

      stall = 1'b1;
      applyStimulus("pix6_2", 11'd6, 10'd2, 24'd1606, 1'b0);
      waitReq(1'b1, 20, "inflightReq");
      dataMask = 24'h00C000;
      applyStimulus("fsInflight", 11'd0, 10'd600, 24'h0, 1'b0);
      stall = 1'b0;
      waitReq(1'b0, 10, "inflightAckDrop");
      waitReq(1'b1, 10, "restartReq");
      checkVal("restartAddr", 24'(mem_addr), 24'h0);
      idle(80);
      applyStimulus("afterDiscard", 11'd0, 10'd0, memWord(19'd0), 1'b0);

      applyStimulus("frameStart5", 11'd0, 10'd600, 24'h0, 1'b0);
      idle(80);
      stall = 1'b1;
      for (int i = 0; i < 20; i++)
         applyStimulus($sformatf("drain%0d", i), 11'(i), 10'd0,
                       (i < 16) ? memWord(19'(i)) : 24'h0, (i < 16) ? 1'b0 : 1'b1);
      for (int k = 0; k < 20; k++) begin
         idle(100);
         checkVal("stallReq", 24'(mem_req), 24'h1);
         checkVal("stallAddr", 24'(mem_addr), 24'd16);
      end
      stall = 1'b0;
      idle(10);
      applyStimulus("stickyUf", 11'd1000, 10'd0, 24'h0, 1'b1);
      stall = 1'b1;
      applyStimulus("resumeWord", 11'd21, 10'd0, memWord(19'd16), 1'b1);
      waitReq(1'b1, 20, "preResetReq");

      rst    = 1'b1;
      pix_en = 1'b1;
      count  = 11'd400;
      line   = 10'd300;
      @(negedge clk);
      rst    = 1'b0;
      pix_en = 1'b0;
      checkVal("midRstRgb", {red, green, blue}, 24'h0);
      checkVal("midRstUf", 24'(underflow), 24'h0);
      checkVal("midRstReq", 24'(mem_req), 24'h0);
      checkVal("midRstAddr", 24'(mem_addr), 24'h0);
      stall    = 1'b0;
      spurious = 1'b1;
      idle(4);
      for (int i = 0; i < 25; i++) begin
         applyStimulus("postRstBlank", 11'd900, 10'(300 + i / 10), 24'h0, 1'b0);
         checkVal("postRstNoReq", 24'(mem_req), 24'h0);
      end

      applyStimulus("frameStart6", 11'd0, 10'd600, 24'h0, 1'b0);
      waitReq(1'b1, 20, "reqAfterFs");
      idle(80);
      spurious = 1'b1;
      idle(4);
      for (int i = 0; i < 18; i++) begin
         applyStimulus($sformatf("stray%0d", i), 11'(i), 10'd0, memWord(19'(i)), 1'b0);
         applyStimulus("blank", 11'd1000, 10'd0, 24'h0, 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule

// File: doc/fb_pixel_fetch.md
FB_PIXEL_FETCH -- requirements
Module: fb_pixel_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning pixel FIFO depth in words (power of 2, ≥4).
REQ-002 SHALL have parameter ADDR_W, default 19, meaning framebuffer word-address width.
REQ-003 SHALL have port clk  input  1  system clock (2x pixel rate); the single clock of the block.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port pix_en  input  1  one-clk pixel-rate strobe, high every second clk.
REQ-006 SHALL have port count  input  11  horizontal pixel counter from the timing stage, 0..1039.
REQ-007 SHALL have port line  input  10  vertical line counter from the timing stage, 0..665.
REQ-008 SHALL have port mem_req  output  1  framebuffer read request.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word address, one 24-bit RGB pixel per word.
REQ-010 SHALL have port mem_ack  input  1  read complete; mem_data valid in the same clk.
REQ-011 SHALL have port mem_data  input  24  {red,green,blue}, 8 bits each.
REQ-012 SHALL have ports red, green, blue  output  8 each  pixel colour feeding the timing/quantiser stage.
REQ-013 SHALL have port underflow  output  1  sticky flag: active pixel requested while FIFO empty.

Function
REQ-014 Active pixel SHALL be defined as count < 800 and line < 600, sampled on clks with pix_en=1.
REQ-015 Frame-start event SHALL be defined as pix_en=1, count=0, line=600 (first vertical-blank line).
REQ-016 FSM states SHALL be S_SYNC (post-reset wait), S_FETCH (issuing reads), S_DONE (480000 words fetched).
REQ-017 Transitions: S_SYNC->S_FETCH on frame-start; S_FETCH->S_DONE when address counter reaches 480000; S_DONE->S_FETCH on frame-start; frame-start in S_FETCH stays in S_FETCH.
REQ-018 On frame-start the block SHALL clear the FIFO, set the address counter to 0, and clear no flag other than the FIFO contents.
REQ-019 Handshake: mem_req SHALL rise only in S_FETCH when FIFO occupancy plus outstanding requests < FIFO_DEPTH; at most one request outstanding.
REQ-020 mem_req and mem_addr SHALL be held stable from assertion until the clk where mem_ack=1; mem_req SHALL drop in that clk, and a new request SHALL not be issued before the following clk.
REQ-021 On mem_ack the block SHALL push mem_data into the FIFO and increment the address counter by 1.
REQ-022 A request outstanding at frame-start SHALL complete normally, and its returned data SHALL be discarded; the address counter SHALL not increment.
REQ-023 mem_ack without an outstanding request SHALL be ignored.
REQ-024 On each active pixel the block SHALL pop one FIFO word; red/green/blue SHALL be registered with the popped value one clk after the pix_en.
REQ-025 On an active pixel with the FIFO empty, the block SHALL output 0/0/0 and set underflow; no pop SHALL occur.
REQ-026 On non-active pixels red/green/blue SHALL be 0 and no pop SHALL occur.
REQ-027 Simultaneous push and pop in one clk SHALL leave occupancy unchanged; a push while full SHALL never occur (guaranteed by REQ-019).

Reset
REQ-028 rst=1 on a clk edge SHALL force: state S_SYNC, FIFO empty, address counter 0, mem_req 0, mem_addr 0, red/green/blue 0, underflow 0.
REQ-029 Reset asserted mid-request SHALL drop mem_req immediately and discard any mem_ack from the abandoned request.

Configuration
REQ-030 With macro FB_TEST_PATTERN_EN defined, the block SHALL ignore memory data and output 8 vertical colour bars, each 100 pixels wide, in active pixels (bar k = {k[2]?FF:00, k[1]?FF:00, k[0]?FF:00}); mem_req SHALL stay 0, and underflow SHALL stay 0.
REQ-031 Without FB_TEST_PATTERN_EN the block SHALL behave as REQ-014..REQ-027, and no pattern logic SHALL be present.

Structure
REQ-032 Package vga_pkg SHALL hold H_ACTIVE=800, H_TOTAL=1040, V_ACTIVE=600, V_TOTAL=666, FB_PIXELS=480000, and the FSM state typedef.
REQ-033 The FIFO SHALL be a sub-module named fb_fifo (synchronous, single clock, occupancy output, synchronous flush input).

Verification
REQ-034 Reset then run one frame with mem_ack 1 clk after mem_req -> first active pixel of the second frame outputs the word at address 0, and underflow=0 across the full frame.
REQ-035 Memory returns data = address -> pixel (count=5, line=2) outputs 24'd1605, one clk after its pix_en.
REQ-036 Stall mem_ack for 2000 clks during active video -> black pixels, underflow=1 and sticky until rst, mem_addr stable throughout the stall.
REQ-037 Assert frame-start while a request is outstanding, then ack it -> data not in FIFO, next mem_addr = 0.
REQ-038 Pulse rst at line 300 -> all outputs 0 next clk, no mem_req until the next line=600, count=0 event.
REQ-039 Build with FB_TEST_PATTERN_EN, pixel count=250 -> red=00, green=FF, blue=00; mem_req=0 always.
